// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the multi-channel SDRAM burst arbiter:
//   - parameter defaults used by sdram_arbiter_mc and sdram_rr_picker
//   - FSM state encoding
//   - one-hot to index helper
// Optional watchdog macro used by the top: SDRAM_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int DefNumChannels   = 4;
  localparam int DefBurstLength   = 8;
  localparam int DefPixelWidth    = 16;
  localparam int DefAddrWidth     = 24;
  localparam int DefTimeoutCycles = 64;

  // Upper bound on channel count; sizes the one-hot helper below.
  localparam int MaxChannels = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic logic [2:0] onehot_to_idx(input logic [MaxChannels-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MaxChannels; i++) begin
      if (oh[i]) idx |= 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// -----------------------------------------------------------------------------
// sdram_rr_picker
// Purely combinational round-robin selector. Searches the request vector
// upward starting at index ptr, wrapping at NumChannels, and returns the
// first requester found as a one-hot grant.
// Ports:
//   req    in  NumChannels        request vector
//   ptr    in  clog2(NumChannels) index searched first
//   grant  out NumChannels        one-hot selected requester
//   valid  out 1                  a requester was found
// -----------------------------------------------------------------------------
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NumChannels = DefNumChannels
) (
  input  logic [NumChannels-1:0]         req,
  input  logic [$clog2(NumChannels)-1:0] ptr,
  output logic [NumChannels-1:0]         grant,
  output logic                           valid
);

  localparam int IdxW = $clog2(NumChannels);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      sum = {1'b0, ptr} + (IdxW + 1)'(i);
      if (sum >= (IdxW + 1)'(NumChannels)) sum = sum - (IdxW + 1)'(NumChannels);
      idx = sum[IdxW-1:0];
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter_mc.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_mc
// Round-robin arbiter granting whole SDRAM bursts to one of NumChannels pixel
// clients. FSM: IDLE -> ARB -> BURST -> DRAIN -> IDLE.
//   IDLE : wait for any request while the SDRAM is idle
//   ARB  : pick next requester (round-robin), latch its address/direction
//   BURST: drive the command, count BurstLengthSDRAM beats
//   DRAIN: wait for the SDRAM to go idle, then pulse o_done for the owner
// Optional feature, macro SDRAM_ARB_TIMEOUT_EN: beat-gap watchdog that forces
// DRAIN after TimeoutCycles silent BURST cycles and sets sticky o_error.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   i_req/i_read      per-channel request and direction (1 = read)
//   i_addr/i_wdata    per-channel burst address and write pixel
//   o_grant           one-hot burst owner
//   o_wr_accept       one-hot, write pixel consumed this cycle
//   o_rdata/o_rd_valid registered read pixel and one-hot valid
//   o_done            one-hot end-of-burst pulse
//   i_sdram_*         SDRAM status, beat strobes and read pixel
//   o_sdram_*         SDRAM command, address and write pixel
//   o_error           sticky watchdog flag (constant 0 without the macro)
// -----------------------------------------------------------------------------
module sdram_arbiter_mc
  import sdram_arb_pkg::*;
#(
  parameter int NumChannels       = DefNumChannels,
  parameter int BurstLengthSDRAM  = DefBurstLength,
  parameter int PixelBitWidth     = DefPixelWidth,
  parameter int AddressWidthSDRAM = DefAddrWidth,
  parameter int TimeoutCycles     = DefTimeoutCycles
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NumChannels-1:0]                     i_req,
  input  logic [NumChannels-1:0]                     i_read,
  input  logic [NumChannels*AddressWidthSDRAM-1:0]   i_addr,
  input  logic [NumChannels*PixelBitWidth-1:0]       i_wdata,
  output logic [NumChannels-1:0]                     o_grant,
  output logic [NumChannels-1:0]                     o_wr_accept,
  output logic [PixelBitWidth-1:0]                   o_rdata,
  output logic [NumChannels-1:0]                     o_rd_valid,
  output logic [NumChannels-1:0]                     o_done,
  input  logic                                       i_sdram_busy,
  input  logic                                       i_sdram_valid_wr,
  input  logic                                       i_sdram_valid_rd,
  input  logic [PixelBitWidth-1:0]                   i_sdram_pixel,
  output logic                                       o_sdram_enable,
  output logic                                       o_sdram_read,
  output logic [AddressWidthSDRAM-1:0]               o_sdram_addr,
  output logic [PixelBitWidth-1:0]                   o_sdram_pixel,
  output logic                                       o_error
);

  localparam int IdxW  = $clog2(NumChannels);
  localparam int BeatW = $clog2(BurstLengthSDRAM + 1);
  localparam int AW    = AddressWidthSDRAM;
  localparam int PW    = PixelBitWidth;

  arb_state_e             state;
  logic [IdxW-1:0]        ptr;       // channel searched first at next ARB
  logic [IdxW-1:0]        gnt_idx;   // index of current burst owner
  logic [IdxW-1:0]        next_ptr;
  logic [BeatW-1:0]       beat_cnt;

  logic [NumChannels-1:0] pick_gnt;
  logic                   pick_valid;
  logic [IdxW-1:0]        pick_idx;
  logic [AW-1:0]          pick_addr;
  logic                   pick_read;
  logic                   beat;

  sdram_rr_picker #(
    .NumChannels(NumChannels)
  ) u_picker (
    .req  (i_req),
    .ptr  (ptr),
    .grant(pick_gnt),
    .valid(pick_valid)
  );

  assign pick_idx  = IdxW'(onehot_to_idx(MaxChannels'(pick_gnt)));
  assign pick_read = i_read[pick_idx];

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (pick_idx == IdxW'(i)) pick_addr = i_addr[i*AW +: AW];
    end
  end

  // Zero when no burst is owned, so the SDRAM sees a quiet bus between bursts.
  always_comb begin
    o_sdram_pixel = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (o_grant[i]) o_sdram_pixel = i_wdata[i*PW +: PW];
    end
  end

  // Only strobes matching the latched direction count, and only in BURST.
  assign beat = (state == ST_BURST) &&
                (o_sdram_read ? i_sdram_valid_rd : i_sdram_valid_wr);

  assign o_wr_accept = (state == ST_BURST && !o_sdram_read && i_sdram_valid_wr)
                       ? o_grant : '0;

  assign next_ptr = (gnt_idx == IdxW'(NumChannels - 1)) ? '0 : gnt_idx + IdxW'(1);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt;  // BURST cycles since the last counted beat
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
  assign o_error = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      gnt_idx        <= '0;
      beat_cnt       <= '0;
      o_grant        <= '0;
      o_rdata        <= '0;
      o_rd_valid     <= '0;
      o_done         <= '0;
      o_sdram_enable <= 1'b0;
      o_sdram_read   <= 1'b0;
      o_sdram_addr   <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_cnt        <= '0;
      o_error        <= 1'b0;
`endif
    end else begin
      o_done     <= '0;
      o_rd_valid <= '0;

      case (state)
        ST_IDLE: begin
          if (|i_req && !i_sdram_busy) state <= ST_ARB;
        end

        ST_ARB: begin
          // Requests sampled here decide; one that already dropped is skipped.
          if (pick_valid) begin
            state          <= ST_BURST;
            o_grant        <= pick_gnt;
            gnt_idx        <= pick_idx;
            o_sdram_addr   <= pick_addr;
            o_sdram_read   <= pick_read;
            o_sdram_enable <= 1'b1;
            beat_cnt       <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_BURST: begin
          if (beat) begin
            if (o_sdram_read) begin
              o_rdata    <= i_sdram_pixel;
              o_rd_valid <= o_grant;
            end
            if (beat_cnt == BeatW'(BurstLengthSDRAM - 1)) begin
              state          <= ST_DRAIN;
              o_sdram_enable <= 1'b0;
              beat_cnt       <= '0;
            end else begin
              beat_cnt <= beat_cnt + BeatW'(1);
            end
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          if (beat) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TmoW'(TimeoutCycles - 1)) begin
            state          <= ST_DRAIN;
            o_sdram_enable <= 1'b0;
            beat_cnt       <= '0;
            tmo_cnt        <= '0;
            o_error        <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
`endif
        end

        ST_DRAIN: begin
          if (!i_sdram_busy) begin
            state        <= ST_IDLE;
            o_done       <= o_grant;
            o_grant      <= '0;
            o_sdram_read <= 1'b0;
            o_sdram_addr <= '0;
            ptr          <= next_ptr;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter_mc.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter_mc
// Self-checking bench for sdram_arbiter_mc (default parameters). Directed
// bursts plus randomized request/direction/strobe patterns, compared against a
// burst-level reference: a round-robin pointer, a beat count per burst, and
// the expected owner of each burst.
// Define SDRAM_ARB_TIMEOUT_EN for both DUT and bench to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter_mc;

  localparam int N   = 4;
  localparam int BL  = 8;
  localparam int PW  = 16;
  localparam int AW  = 24;
  localparam int TMO = 64;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      i_req, i_read;
  logic [N*AW-1:0]   i_addr;
  logic [N*PW-1:0]   i_wdata;
  logic [N-1:0]      o_grant, o_wr_accept, o_rd_valid, o_done;
  logic [PW-1:0]     o_rdata;
  logic              i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd;
  logic [PW-1:0]     i_sdram_pixel;
  logic              o_sdram_enable, o_sdram_read, o_error;
  logic [AW-1:0]     o_sdram_addr;
  logic [PW-1:0]     o_sdram_pixel;

  always #5 CLK = ~CLK;

  sdram_arbiter_mc #(
    .NumChannels(N), .BurstLengthSDRAM(BL), .PixelBitWidth(PW),
    .AddressWidthSDRAM(AW), .TimeoutCycles(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_read(i_read), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_grant(o_grant), .o_wr_accept(o_wr_accept), .o_rdata(o_rdata),
    .o_rd_valid(o_rd_valid), .o_done(o_done),
    .i_sdram_busy(i_sdram_busy), .i_sdram_valid_wr(i_sdram_valid_wr),
    .i_sdram_valid_rd(i_sdram_valid_rd), .i_sdram_pixel(i_sdram_pixel),
    .o_sdram_enable(o_sdram_enable), .o_sdram_read(o_sdram_read),
    .o_sdram_addr(o_sdram_addr), .o_sdram_pixel(o_sdram_pixel),
    .o_error(o_error)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rr_ptr   = 0;     // reference: channel searched first
  logic        exp_err  = 1'b0;  // reference: sticky watchdog flag
  logic [AW-1:0] addr_tab [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Round-robin rule: first requester at or after rr_ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] req);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (rr_ptr + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic load_addrs(input logic [AW-1:0] addr0);
    for (int k = 0; k < N; k++) begin
      addr_tab[k] = (k == 0) ? addr0 : AW'($urandom);
      i_addr[k*AW +: AW] = addr_tab[k];
    end
  endtask

  task automatic wait_enable(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge CLK); #1;
      if (o_sdram_enable) seen = 1'b1;
    end
    check("burst_start", seen, 1);
  endtask

  // Release the SDRAM, expect exactly one o_done pulse for the owner.
  task automatic finish_burst(input int g);
    logic [N-1:0] oh;
    bit seen;
    oh = N'(1) << g;
    @(negedge CLK);
    i_sdram_valid_wr = 1'b0;
    i_sdram_valid_rd = 1'b0;
    i_req            = '0;
    i_sdram_busy     = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check("done_while_busy", o_done, 0);
      check("enable_in_drain", o_sdram_enable, 0);
    end
    @(negedge CLK);
    i_sdram_busy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge CLK); #1;
      if (o_done != '0) seen = 1'b1;
    end
    check("done", o_done, oh);
    @(posedge CLK); #1;
    check("done_pulse", o_done, 0);
    check("error", o_error, exp_err);
    rr_ptr = (g + 1) % N;
  endtask

  task automatic do_burst(input logic [N-1:0] req, input logic [N-1:0] rd,
                          input bit busy_hold, input int extra, input bit garble,
                          input logic [AW-1:0] addr0);
    int g, cnt, post;
    logic [N-1:0] oh;
    bit is_rd, seen, vdir, vother, counted;
    logic [PW-1:0] exp_px;
    g     = model_pick(req);
    oh    = N'(1) << g;
    is_rd = rd[g];
    @(negedge CLK);
    load_addrs(addr0);
    i_req        = req;
    i_read       = rd;
    i_sdram_busy = busy_hold;
    if (busy_hold) begin
      repeat (3) begin
        @(posedge CLK); #1;
        check("idle_while_busy", o_sdram_enable, 0);
      end
      @(negedge CLK);
      i_sdram_busy = 1'b0;
    end
    wait_enable(seen);
    if (!seen) return;
    check("grant", o_grant, oh);
    check("addr", o_sdram_addr, addr_tab[g]);
    check("dir", o_sdram_read, is_rd);
    cnt  = 0;
    post = 0;
    for (int c = 0; c < 300; c++) begin
      if (cnt == BL) begin
        if (post >= extra) break;
        post++;
      end
      @(negedge CLK);
      i_sdram_busy  = 1'b1;
      i_wdata       = {$urandom, $urandom};
      i_sdram_pixel = PW'($urandom);
      if (garble) begin
        i_req  = N'($urandom);
        i_read = N'($urandom);
        i_addr = {$urandom, $urandom, $urandom};
      end
      vdir   = ($urandom_range(0, 2) != 0);
      vother = $urandom_range(0, 1) == 1;
      i_sdram_valid_rd = is_rd ? vdir : vother;
      i_sdram_valid_wr = is_rd ? vother : vdir;
      counted = vdir && (cnt < BL);
      #1;
      check("wr_accept", o_wr_accept, (counted && !is_rd) ? oh : '0);
      if (cnt < BL) begin
        check("wr_pixel", o_sdram_pixel, i_wdata[g*PW +: PW]);
        check("addr_hold", o_sdram_addr, addr_tab[g]);
        check("grant_hold", o_grant, oh);
      end
      exp_px = i_sdram_pixel;
      @(posedge CLK); #1;
      check("rd_valid", o_rd_valid, (counted && is_rd) ? oh : '0);
      if (counted && is_rd) check("rdata", o_rdata, exp_px);
      if (counted) cnt++;
      check("enable", o_sdram_enable, cnt < BL);
      check("done_early", o_done, 0);
    end
    finish_burst(g);
  endtask

  // Write burst with a long silent gap after three beats.
  task automatic gap_burst();
    int g;
    bit seen;
    g = model_pick(4'b1111);
    @(negedge CLK);
    load_addrs(AW'($urandom));
    i_req        = 4'b1111;
    i_read       = 4'b0000;
    i_sdram_busy = 1'b0;
    wait_enable(seen);
    if (!seen) return;
    check("gap_grant", o_grant, N'(1) << g);
    @(negedge CLK);
    i_req        = '0;
    i_sdram_busy = 1'b1;
    repeat (3) begin
      i_sdram_valid_wr = 1'b1;
      @(negedge CLK);
    end
    i_sdram_valid_wr = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(posedge CLK); #1;
        n++;
        if (!o_sdram_enable) seen = 1'b1;
      end
      check("timeout_cycles", n, TMO);
      check("error_set", o_error, 1);
      exp_err = 1'b1;
    end
`else
    repeat (100) @(posedge CLK);
    #1;
    check("no_timeout", o_sdram_enable, 1);
    check("error_zero", o_error, 0);
    for (int b = 0; b < BL - 3; b++) begin
      @(negedge CLK);
      i_sdram_valid_wr = 1'b1;
    end
    @(negedge CLK);
    i_sdram_valid_wr = 1'b0;
    #1;
    check("gap_burst_end", o_sdram_enable, 0);
`endif
    finish_burst(g);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  o_grant, 0);
    check({tag, "_enable"}, o_sdram_enable, 0);
    check({tag, "_addr"},   o_sdram_addr, 0);
    check({tag, "_read"},   o_sdram_read, 0);
    check({tag, "_rdv"},    o_rd_valid, 0);
    check({tag, "_rdata"},  o_rdata, 0);
    check({tag, "_done"},   o_done, 0);
    check({tag, "_error"},  o_error, 0);
    check({tag, "_wracc"},  o_wr_accept, 0);
    check({tag, "_pixel"},  o_sdram_pixel, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected end of test");
    $fatal(1, "global timeout");
  end

  initial begin
    bit seen;
    RST = 1'b1;
    i_req = '0; i_read = '0; i_addr = '0; i_wdata = '0;
    i_sdram_busy = 1'b0; i_sdram_valid_wr = 1'b0; i_sdram_valid_rd = 1'b0;
    i_sdram_pixel = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Single write requester, directed address, stray strobes afterwards.
    do_burst(4'b0001, 4'b0000, 1'b1, 2, 1'b0, 24'h000100);

    // All channels requesting: rotation through every channel.
    for (int b = 0; b < 5; b++)
      do_burst(4'b1111, N'($urandom), 1'b0, 0, 1'b1, AW'($urandom));

    // Channel 2 read with stray write strobes and trailing beats.
    do_burst(4'b0100, 4'b0100, 1'b0, 2, 1'b0, AW'($urandom));

    // Randomized mix.
    for (int b = 0; b < 20; b++)
      do_burst(N'($urandom_range(1, 15)), N'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 1) == 1, AW'($urandom));

    // A request that falls before arbitration is not granted.
    @(negedge CLK);
    i_req = 4'b0010;
    @(negedge CLK);
    i_req = 4'b0000;
    repeat (5) begin
      @(posedge CLK); #1;
      check("dropped_req", o_sdram_enable, 0);
    end

    gap_burst();

    // Leave the pointer at channel 1, then reset in the middle of a burst.
    do_burst(4'b0001, 4'b0000, 1'b0, 0, 1'b0, AW'($urandom));
    @(negedge CLK);
    i_req  = 4'b0100;
    i_read = 4'b0000;
    wait_enable(seen);
    check("pre_reset_grant", o_grant, 4'b0100);
    @(negedge CLK);
    i_sdram_busy = 1'b1;
    repeat (3) begin
      i_sdram_valid_wr = 1'b1;
      @(negedge CLK);
    end
    i_sdram_valid_wr = 1'b1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check_all_zero("midreset");
    @(negedge CLK);
    RST = 1'b0;
    i_sdram_valid_wr = 1'b0;
    i_sdram_busy = 1'b0;
    i_req = '0;
    repeat (3) begin
      @(posedge CLK); #1;
      check("no_done_after_reset", o_done, 0);
    end
    rr_ptr  = 0;
    exp_err = 1'b0;
    do_burst(4'b1111, 4'b0000, 1'b0, 0, 1'b0, AW'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
